// File: rtl/video_pkg.sv
// Shared video definitions: mode encodings, scheduler states, pixel sources.
package video_pkg;

    localparam int unsigned RGB_W = 24;

    typedef enum logic [1:0] {
        MODE_PATTERN = 2'd0,
        MODE_CAM0    = 2'd1,
        MODE_CAM1    = 2'd2,
        MODE_STITCH  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        FALLBACK = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_PAT  = 2'd0,
        SRC_CAM0 = 2'd1,
        SRC_CAM1 = 2'd2
    } src_e;

endpackage

// File: rtl/pix_mux3.sv
// 3:1 registered pixel mux with matching one-clock delay on hs/vs/de.
module pix_mux3
    import video_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  src_e             sel_i,
    input  logic             hs_i,
    input  logic             vs_i,
    input  logic             de_i,
    input  logic [RGB_W-1:0] pat_i,
    input  logic [RGB_W-1:0] c0_i,
    input  logic [RGB_W-1:0] c1_i,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    output logic [RGB_W-1:0] rgb_o
);

    logic [RGB_W-1:0] pix_d;
    logic [RGB_W-1:0] rgb_q;
    logic             hs_q;
    logic             vs_q;
    logic             de_q;

    // Pick the pixel for the selected source.
    always_comb begin
        pix_d = pat_i;
        case (sel_i)
            SRC_CAM0: pix_d = c0_i;
            SRC_CAM1: pix_d = c1_i;
            default:  pix_d = pat_i;
        endcase
    end

    // Register timing and pixel; pixel is blanked outside active video.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs_i;
            vs_q  <= vs_i;
            de_q  <= de_i;
            rgb_q <= de_i ? pix_d : '0;
        end
    end

    assign hs_o  = hs_q;
    assign vs_o  = vs_q;
    assign de_o  = de_q;
    assign rgb_o = rgb_q;

endmodule

// File: rtl/hdmi_stitch_scheduler.sv
// Per-frame source scheduler between the timing generator and the HDMI transmitter.
// Shares each line between cam0/cam1 FIFOs and the colour-bar pattern, and falls
// back to the pattern for the rest of a frame after a FIFO underflow.
module hdmi_stitch_scheduler
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_SPLIT  = 960,
    parameter int unsigned XW       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_req,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             de_in,
    input  logic [RGB_W-1:0] pat_rgb,
    input  logic             c0_empty,
    input  logic [RGB_W-1:0] c0_data,
    output logic             c0_rd,
    input  logic             c1_empty,
    input  logic [RGB_W-1:0] c1_data,
    output logic             c1_rd,
    output logic             frame_start,
    output logic             hs_out,
    output logic             vs_out,
    output logic             de_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic             underflow,
    output logic [15:0]      uf_frames,
    output logic [1:0]       mode_act
);

    localparam logic [XW-1:0] X_SPLIT = XW'(H_SPLIT);
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic          vs_d_q;
    logic [XW-1:0] x_q, x_d;
    logic          underflow_q;
    logic          uf_flag_q, uf_flag_d;
    logic [15:0]   uf_cnt_q, uf_cnt_d;
    logic          vs_rise;
    logic          uf_evt;
    logic          uf_inc;
    src_e          src;
    src_e          sel;

    assign vs_rise = vs_in & ~vs_d_q;

    // Source for the current pixel; cameras only ever feed the output in RUN.
    always_comb begin
        src = SRC_PAT;
        if (state_q == RUN) begin
            case (mode_q)
                MODE_CAM0:   src = SRC_CAM0;
                MODE_CAM1:   src = SRC_CAM1;
                MODE_STITCH: src = (x_q < X_SPLIT) ? SRC_CAM0 : SRC_CAM1;
                default:     src = SRC_PAT;
            endcase
        end
    end

    assign uf_evt = de_in & (((src == SRC_CAM0) & c0_empty) | ((src == SRC_CAM1) & c1_empty));
    assign c0_rd  = de_in & (src == SRC_CAM0) & ~c0_empty;
    assign c1_rd  = de_in & (src == SRC_CAM1) & ~c1_empty;
    assign sel    = uf_evt ? SRC_PAT : src;

    // Next state: mode is latched only on vs_rise, which takes priority over underflow.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (vs_rise) begin
            mode_d  = mode_e'(mode_req);
            state_d = (mode_req == 2'd0) ? IDLE : RUN;
        end else if ((state_q == RUN) && uf_evt) begin
            state_d = FALLBACK;
        end
    end

    // FSM state and active-mode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_PATTERN;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Line position (saturating) and per-frame underflow bookkeeping.
    always_comb begin
        x_d = '0;
        if (de_in) begin
            x_d = (x_q == X_LAST) ? x_q : x_q + 1'b1;
        end
        uf_flag_d = vs_rise ? uf_evt : (uf_flag_q | uf_evt);
        uf_inc    = uf_evt & (vs_rise | ~uf_flag_q);
        uf_cnt_d  = (uf_inc && (uf_cnt_q != 16'hFFFF)) ? uf_cnt_q + 16'd1 : uf_cnt_q;
    end

    // Edge detector, x counter and underflow status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d_q      <= 1'b0;
            x_q         <= '0;
            underflow_q <= 1'b0;
            uf_flag_q   <= 1'b0;
            uf_cnt_q    <= '0;
        end else begin
            vs_d_q      <= vs_in;
            x_q         <= x_d;
            underflow_q <= underflow_q | uf_evt;
            uf_flag_q   <= uf_flag_d;
            uf_cnt_q    <= uf_cnt_d;
        end
    end

    pix_mux3 u_mux (
        .clk   (clk),
        .rst   (rst),
        .sel_i (sel),
        .hs_i  (hs_in),
        .vs_i  (vs_in),
        .de_i  (de_in),
        .pat_i (pat_rgb),
        .c0_i  (c0_data),
        .c1_i  (c1_data),
        .hs_o  (hs_out),
        .vs_o  (vs_out),
        .de_o  (de_out),
        .rgb_o (rgb_out)
    );

    assign frame_start = vs_rise;
    assign underflow   = underflow_q;
    assign uf_frames   = uf_cnt_q;
    assign mode_act    = mode_q;

endmodule

// File: tb/tb_hdmi_stitch_scheduler.sv
// Self-checking bench for hdmi_stitch_scheduler against a per-frame reference model.
module tb_hdmi_stitch_scheduler;

    localparam int HA = 1920;
    localparam int HS = 960;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_req;
    logic        hs_in, vs_in, de_in;
    logic [23:0] pat_rgb, c0_data, c1_data;
    logic        c0_empty, c1_empty;
    logic        c0_rd, c1_rd, frame_start;
    logic        hs_out, vs_out, de_out;
    logic [23:0] rgb_out;
    logic        underflow;
    logic [15:0] uf_frames;
    logic [1:0]  mode_act;

    always #5 clk = ~clk;

    hdmi_stitch_scheduler #(
        .H_ACTIVE (1920),
        .H_SPLIT  (960),
        .XW       (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_req    (mode_req),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .de_in       (de_in),
        .pat_rgb     (pat_rgb),
        .c0_empty    (c0_empty),
        .c0_data     (c0_data),
        .c0_rd       (c0_rd),
        .c1_empty    (c1_empty),
        .c1_data     (c1_data),
        .c1_rd       (c1_rd),
        .frame_start (frame_start),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .de_out      (de_out),
        .rgb_out     (rgb_out),
        .underflow   (underflow),
        .uf_frames   (uf_frames),
        .mode_act    (mode_act)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Reference model: per-frame mode, fallback flag, sticky flags, FIFO sequence counters
    int   m_mode, m_cnt;
    bit   m_fb, m_flag, m_uf, m_vs_prev;
    int   c0_seq = 0, c1_seq = 0;

    // Observation tallies and per-frame stimulus options
    int   line_rd0, line_rd1, fs_cnt, first_c1;
    int   inj_cam, inj_l0, inj_x0, inj_l1, inj_x1;
    int   chg_line, long_line, rst_line, rst_px;
    logic [1:0] chg_mreq;
    bit   chk_pops;

    task automatic clr_opts();
        inj_cam = -1; inj_l0 = -1; inj_x0 = -1; inj_l1 = -1; inj_x1 = -1;
        chg_line = -1; long_line = -1; rst_line = -1; rst_px = -1;
        chg_mreq = 2'd0; chk_pops = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_fb = 0; m_flag = 0; m_uf = 0; m_vs_prev = 0;
    endtask

    function automatic bit rnd_e(input int pct);
        return $urandom_range(0, 999) < pct;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"}, 32'(rgb_out), 32'd0);
        check({tag, "_de"},  32'(de_out),  32'd0);
        check({tag, "_hs"},  32'(hs_out),  32'd0);
        check({tag, "_vs"},  32'(vs_out),  32'd0);
        check({tag, "_uf"},  32'(underflow), 32'd0);
        check({tag, "_ufn"}, 32'(uf_frames), 32'd0);
        check({tag, "_mode"}, 32'(mode_act), 32'd0);
        check({tag, "_c0rd"}, 32'(c0_rd), 32'd0);
        check({tag, "_c1rd"}, 32'(c1_rd), 32'd0);
    endtask

    // One pixel clock: drive inputs, check pops, then check registered outputs.
    // px is the position within the de run (-1 outside active video).
    task automatic cyc(input bit hs, input bit vs, input bit de, input bit e0, input bit e1,
                       input logic [1:0] mreq, input int px, input int pos);
        int cam, xs;
        bit vsr, uf;
        logic [23:0] pix;
        hs_in = hs; vs_in = vs; de_in = de; c0_empty = e0; c1_empty = e1; mode_req = mreq;
        pat_rgb = 24'($urandom);
        c0_data = e0 ? 24'($urandom) : {8'hA0, c0_seq[15:0]};
        c1_data = e1 ? 24'($urandom) : {8'hB1, c1_seq[15:0]};
        vsr = vs && !m_vs_prev;
        xs  = (px > HA - 1) ? HA - 1 : px;
        cam = -1;
        if (de && !m_fb && m_mode != 0) begin
            if (m_mode == 1)      cam = 0;
            else if (m_mode == 2) cam = 1;
            else                  cam = (xs < HS) ? 0 : 1;
        end
        uf  = (cam == 0 && e0) || (cam == 1 && e1);
        pix = !de ? 24'd0 : (cam == 0 && !e0) ? c0_data : (cam == 1 && !e1) ? c1_data : pat_rgb;
        #3;
        check("c0_rd", 32'(c0_rd), 32'(cam == 0 && !e0));
        check("c1_rd", 32'(c1_rd), 32'(cam == 1 && !e1));
        check("frame_start", 32'(frame_start), 32'(vsr));
        line_rd0 += int'(c0_rd);
        line_rd1 += int'(c1_rd);
        fs_cnt   += int'(frame_start);
        if (c1_rd && first_c1 < 0) first_c1 = pos;
        @(posedge clk); #1;
        if (cam == 0 && !e0) c0_seq++;
        if (cam == 1 && !e1) c1_seq++;
        if (uf) begin
            m_uf = 1;
            if (!m_flag || vsr) m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        end
        if (vsr) begin
            m_mode = int'(mreq); m_fb = 0; m_flag = uf;
        end else if (uf) begin
            m_fb = 1; m_flag = 1;
        end
        m_vs_prev = vs;
        check("hs_out", 32'(hs_out), 32'(hs));
        check("vs_out", 32'(vs_out), 32'(vs));
        check("de_out", 32'(de_out), 32'(de));
        check("rgb_out", 32'(rgb_out), 32'(pix));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("uf_frames", 32'(uf_frames), 32'(m_cnt));
        check("mode_act", 32'(mode_act), 32'(m_mode));
    endtask

    // Asynchronous reset in the middle of a cycle, held for two edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] mreq, input int nlines, input int len, input int pct);
        int l_len;
        bit e0, e1;
        logic [1:0] cur;
        fs_cnt = 0; first_c1 = -1;
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, rnd_e(pct), rnd_e(pct), mreq, -1, -1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, rnd_e(pct), rnd_e(pct), mreq, -1, -1);
        for (int l = 0; l < nlines; l++) begin
            cur = (chg_line >= 0 && l >= chg_line) ? chg_mreq : mreq;
            for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, cur, -1, -1);
            for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, cur, -1, -1);
            l_len = (len > 0) ? len : int'($urandom_range(20, 300));
            if (l == long_line) l_len = HA + 8;
            line_rd0 = 0; line_rd1 = 0;
            for (int p = 0; p < l_len; p++) begin
                if (l == rst_line && p == rst_px) begin
                    do_reset();
                    break;
                end
                e0 = rnd_e(pct) || (inj_cam == 0 && ((l == inj_l0 && p == inj_x0) || (l == inj_l1 && p == inj_x1)));
                e1 = rnd_e(pct) || (inj_cam == 1 && ((l == inj_l0 && p == inj_x0) || (l == inj_l1 && p == inj_x1)));
                cyc(0, 0, 1, e0, e1, cur, p, l * 100000 + p);
            end
            if (chk_pops) begin
                check("line_c0_pops", 32'(line_rd0), 32'((l_len < HS) ? l_len : HS));
                check("line_c1_pops", 32'(line_rd1), 32'((l_len < HS) ? 0 : l_len - HS));
            end
            if (l > rst_line && rst_line >= 0) begin
                check("post_rst_pops", 32'(line_rd0 + line_rd1), 32'd0);
            end
            for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, cur, -1, -1);
        end
        check("frame_start_count", 32'(fs_cnt), 32'd1);
        clr_opts();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        mode_req = 2'd0; hs_in = 0; vs_in = 0; de_in = 0;
        pat_rgb = '0; c0_data = '0; c1_data = '0; c0_empty = 1'b1; c1_empty = 1'b1;
        model_reset();
        clr_opts();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Pattern mode for two frames, random FIFO states must not cause pops
        run_frame(2'd0, 3, 0, 50);
        run_frame(2'd0, 3, 0, 50);

        // Stitch with full FIFOs; last line overruns to exercise x saturation
        chk_pops = 1'b1; long_line = 2;
        run_frame(2'd3, 3, HA, 0);

        // cam0 underflow at x=100 of line 5, then recovery next frame
        inj_cam = 0; inj_l0 = 4; inj_x0 = 100;
        run_frame(2'd1, 6, 200, 0);
        check("t3_underflow", 32'(underflow), 32'd1);
        check("t3_uf_frames", 32'(uf_frames), 32'd1);
        run_frame(2'd1, 3, 200, 0);

        // Two empty events in one cam1 frame count one frame
        inj_cam = 1; inj_l0 = 1; inj_x0 = 10; inj_l1 = 2; inj_x1 = 30;
        run_frame(2'd2, 4, 150, 0);
        check("t4_uf_frames", 32'(uf_frames), 32'd2);

        // Mode request changes mid-frame; takes effect at the next frame start
        chg_line = 2; chg_mreq = 2'd2;
        run_frame(2'd1, 4, 100, 0);
        check("t5_mode_hold", 32'(mode_act), 32'd1);
        run_frame(2'd2, 3, 100, 0);
        check("t5_first_c1_pop", 32'(first_c1), 32'd0);

        // Reset in the middle of a line, then mode applied at next frame start
        rst_line = 1; rst_px = 50;
        run_frame(2'd1, 3, 120, 0);
        check("t6_uf_frames", 32'(uf_frames), 32'd0);
        check("t6_mode_idle", 32'(mode_act), 32'd0);
        run_frame(2'd2, 2, 100, 0);
        check("t6_first_c1_pop", 32'(first_c1), 32'd0);

        // Randomized frames: random mode, line lengths and FIFO empties
        for (int f = 0; f < 10; f++) begin
            run_frame(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 0, int'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
